piso_serializer_8bit: RTL and testbench
=======================================

# piso_serializer_8bit

Parallel-in/serial-out transmitter that drains an 8-bit register word onto a single serial line. It accepts one word through a valid/ready handshake and shifts it out one bit per `bit_en` strobe, MSB-first or LSB-first. It then signals completion and returns to idle. It sits downstream of the team's parallel-load data registers and is paced by an external bit-rate strobe generator.

## Interface
- `WIDTH`, default 8: word width in bits; legal range is WIDTH >= 2.
- `LSB_FIRST`, default 0: 0 shifts the MSB out first; 1 shifts the LSB out first.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `async_rst`  in  1  reset, asynchronous, active-low. Forces all state to reset values immediately.
- `in_valid`  in  1  source offers `data_in`.
- `in_ready`  out  1  block can accept a word; high exactly when in IDLE.
- `data_in`  in  WIDTH  parallel word; sampled only on accept.
- `bit_en`  in  1  one-cycle bit-period strobe; marks the end of the current bit.
- `ser_out`  out  1  serial data, registered; idles high.
- `ser_active`  out  1  high while a frame's bits are on `ser_out`.
- `frame_done`  out  1  one-cycle pulse after the last bit ends.

## Operation
- States: IDLE and SHIFT. Internal state is a WIDTH-bit shift register plus a bit counter of $clog2(WIDTH) bits.
- IDLE:
  - `in_ready`=1 and `ser_out`=1.
  - `bit_en` is ignored.
  - Accept occurs on a rising edge with `in_valid`=1. On accept: load `data_in` into the shift register, set the counter to 0, and go to SHIFT.
  - On the same edge, register the first bit onto `ser_out` (bit WIDTH-1 if LSB_FIRST=0, else bit 0) and set `ser_active`<=1.
- SHIFT:
  - `in_ready`=0. `in_valid` and `data_in` are ignored, and the source must hold its word until accepted.
  - On an edge with `bit_en`=1 and counter < WIDTH-1: shift by one, register the next bit onto `ser_out`, and increment the counter.
  - On an edge with `bit_en`=1 and counter == WIDTH-1: go to IDLE, set `ser_out`<=1, `ser_active`<=0 and `frame_done`<=1.
  - On an edge with `bit_en`=0: hold all state.
- `frame_done` is registered and high for exactly one cycle, which is the first IDLE cycle after a frame.
- A `bit_en` pulse in the accept cycle does not advance the frame. Bit 0 of the frame lasts until the first `bit_en` strobe after accept.
- Reset asserted mid-frame aborts the frame and emits no `frame_done`. The next accept after release starts a clean frame.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `ser_out`=1, `ser_active`=0, `frame_done`=0, counter=0, shift register=0.
- Latency: the first data bit appears on `ser_out` one cycle after the accept edge (E0).
- With `bit_en` tied high:
  - Bit k is on `ser_out` in the cycle after edge Ek, for k = 0..WIDTH-1.
  - Edge E(WIDTH) returns the block to IDLE and raises `frame_done`.
  - The earliest next accept is edge E(WIDTH+1), so the minimum frame period is WIDTH+1 cycles (9 for WIDTH=8).
- Each bit is held for exactly the number of cycles between consecutive `bit_en` strobes. The last bit ends on the WIDTH-th strobe after accept.
- `in_ready` is decoded from state and is high during reset. No accept can occur until the first rising edge after `async_rst` deasserts.

## Test plan
- Reset check: assert `async_rst`=0 with random inputs toggling -> `in_ready`=1, `ser_out`=1, `ser_active`=0, `frame_done`=0.
- MSB-first, `bit_en`=1: accept 0xB1 -> `ser_out` = 1,0,1,1,0,0,0,1 on cycles E0+1..E7+1. Then `ser_out`=1, `ser_active`=0 and `frame_done`=1 for one cycle after E8; the next accept is possible at E9.
- LSB_FIRST=1, `bit_en`=1: accept 0xB1 -> `ser_out` = 1,0,0,0,1,1,0,1, with `frame_done` after E8.
- Paced with back-pressure: `bit_en` once every 4 cycles; accept 0x5A, then hold `in_valid`=1 with 0xC3 during SHIFT.
  - Each bit of 0x5A must be held for 4 cycles.
  - `in_ready` must stay 0 during SHIFT.
  - 0xC3 must be accepted only in the IDLE cycle after `frame_done`, and shifted out intact.
- `bit_en` coinciding with the accept edge -> it is ignored; bit 0 is still held until the next `bit_en`.
- Reset mid-frame: accept 0xFF, pulse `async_rst` low after 3 bits have shifted.
  - Immediately: `ser_out`=1, `ser_active`=0, and no `frame_done` pulse.
  - A following accept of 0x0F emits 0,0,0,0,1,1,1,1 (MSB-first) and one `frame_done`.

Source files
------------

// File: rtl/piso_serializer_8bit_if.sv
// Handshake and serial-line bundle for the parallel-in/serial-out transmitter.
// The master side offers words and bit strobes, and the slave side is the serializer.
interface piso_serializer_8bit_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_in;
    logic             bit_en;
    logic             ser_out;
    logic             ser_active;
    logic             frame_done;

    modport master (
        output in_valid, data_in, bit_en,
        input  in_ready, ser_out, ser_active, frame_done
    );

    modport slave (
        input  in_valid, data_in, bit_en,
        output in_ready, ser_out, ser_active, frame_done
    );
endinterface

// File: rtl/piso_serializer_8bit.sv
// Drains one accepted WIDTH-bit word onto a registered serial line, one bit per bit_en strobe.
// The shift direction is fixed by LSB_FIRST. The line idles high.
module piso_serializer_8bit #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b0
) (
    input  logic                  clk,
    input  logic                  async_rst,
    piso_serializer_8bit_if.slave bus
);
    localparam int unsigned    CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_cnt;
    logic             r_ser;
    logic             r_active;
    logic             r_done;

    logic [WIDTH-1:0] w_shifted;
    logic             w_first_bit;
    logic             w_next_bit;

    // The outgoing bit always sits at the leading end of the register,
    // so the next bit is read from the word after the shift.
    always_comb begin
        w_shifted   = LSB_FIRST ? {1'b0, r_shreg[WIDTH-1:1]} : {r_shreg[WIDTH-2:0], 1'b0};
        w_first_bit = LSB_FIRST ? bus.data_in[0] : bus.data_in[WIDTH-1];
        w_next_bit  = LSB_FIRST ? w_shifted[0] : w_shifted[WIDTH-1];
    end

    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            r_state  <= IDLE;
            r_shreg  <= '0;
            r_cnt    <= '0;
            r_ser    <= 1'b1;
            r_active <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_shreg  <= bus.data_in;
                        r_cnt    <= '0;
                        r_ser    <= w_first_bit;
                        r_active <= 1'b1;
                        r_state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bus.bit_en) begin
                        if (r_cnt == LAST) begin
                            r_state  <= IDLE;
                            r_ser    <= 1'b1;
                            r_active <= 1'b0;
                            r_done   <= 1'b1;
                        end else begin
                            r_shreg <= w_shifted;
                            r_ser   <= w_next_bit;
                            r_cnt   <= r_cnt + CW'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // in_ready follows the state register directly, so it is high throughout reset.
    assign bus.in_ready   = (r_state == IDLE);
    assign bus.ser_out    = r_ser;
    assign bus.ser_active = r_active;
    assign bus.frame_done = r_done;
endmodule

// File: tb/tb_piso_serializer_8bit.sv
// Bench for piso_serializer_8bit: MSB-first and LSB-first instances are checked
// against a queue-based model of the frame, under directed and random stimulus.
module tb_piso_serializer_8bit;
    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic async_rst;
    always #5 clk = ~clk;

    piso_serializer_8bit_if #(.WIDTH(W)) if_m ();
    piso_serializer_8bit_if #(.WIDTH(W)) if_l ();

    piso_serializer_8bit #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .async_rst(async_rst), .bus(if_m.slave)
    );
    piso_serializer_8bit #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .async_rst(async_rst), .bus(if_l.slave)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model: the bits still to be sent, in line order. The head is the bit on the line.
    bit m_lsb;
    bit m_busy;
    bit m_done;
    bit m_q[$];

    // {in_ready, ser_out, ser_active, frame_done}
    function automatic logic [3:0] model_obs();
        return {~m_busy, (m_busy ? m_q[0] : 1'b1), m_busy, m_done};
    endfunction

    function automatic logic [3:0] dut_obs(bit lsb);
        if (lsb) return {if_l.in_ready, if_l.ser_out, if_l.ser_active, if_l.frame_done};
        return {if_m.in_ready, if_m.ser_out, if_m.ser_active, if_m.frame_done};
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        m_done = 1'b0;
        m_q.delete();
    endtask

    task automatic model_edge(bit v, logic [W-1:0] d, bit b);
        bit nd = 1'b0;
        if (!async_rst) begin
            model_reset();
            return;
        end
        if (!m_busy) begin
            if (v) begin
                m_q.delete();
                for (int k = 0; k < W; k++) m_q.push_back(m_lsb ? d[k] : d[W-1-k]);
                m_busy = 1'b1;
            end
        end else if (b) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) begin
                m_busy = 1'b0;
                nd     = 1'b1;
            end
        end
        m_done = nd;
    endtask

    // Drive the selected instance, clock one edge, advance the model, and settle 1 time unit past the edge.
    task automatic step(bit v, logic [W-1:0] d, bit b);
        if (m_lsb) begin
            if_l.in_valid = v; if_l.data_in = d; if_l.bit_en = b;
            if_m.in_valid = 1'b0; if_m.data_in = '0; if_m.bit_en = 1'b0;
        end else begin
            if_m.in_valid = v; if_m.data_in = d; if_m.bit_en = b;
            if_l.in_valid = 1'b0; if_l.data_in = '0; if_l.bit_en = 1'b0;
        end
        @(posedge clk);
        model_edge(v, d, b);
        cyc++;
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1);
    endtask

    task automatic test_reset();
        logic [3:0] obs;
        async_rst = 1'b0;
        m_lsb = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
            for (int s = 0; s < 2; s++) begin
                obs = dut_obs(s[0]);
                checks++;
                if (obs !== 4'b1100) begin
                    failures++;
                    $display("FAIL reset_state dut=%0d cyc=%0d actual=%b required=1100", s, cyc, obs);
                end
            end
        end
        async_rst = 1'b1;
        step(1'b0, '0, 1'b0);
    endtask

    task automatic test_bit_order(bit lsb, logic [0:W-1] seq, logic [W-1:0] word);
        logic [3:0] obs;
        m_lsb = lsb;
        step(1'b1, word, 1'b1);
        for (int k = 0; k < W; k++) begin
            if (k > 0) step(1'b0, '0, 1'b1);
            obs = dut_obs(lsb);
            checks++;
            if (obs !== {1'b0, seq[k], 1'b1, 1'b0} || obs !== model_obs()) begin
                failures++;
                $display("FAIL bit_order lsb=%0d bit=%0d actual=%b required=%b", lsb, k, obs, {1'b0, seq[k], 2'b10});
            end
        end
        step(1'b0, '0, 1'b1);
        obs = dut_obs(lsb);
        checks++;
        if (obs !== 4'b1101) begin
            failures++;
            $display("FAIL frame_end lsb=%0d actual=%b required=1101", lsb, obs);
        end
        step(1'b1, 8'($urandom), 1'b1);
        obs = dut_obs(lsb);
        checks++;
        if (obs[1:0] !== 2'b10 || obs !== model_obs()) begin
            failures++;
            $display("FAIL accept_at_E9 lsb=%0d actual=%b required=%b", lsb, obs, model_obs());
        end
        drain();
    endtask

    task automatic test_paced_backpressure();
        logic [3:0] obs;
        int dones = 0, active_first = 0, done_cyc = -1, restart_cyc = -1;
        bit prev_active = 1'b0;
        m_lsb = 1'b0;
        for (int i = 0; i < 120 && dones < 2; i++) begin
            step(1'b1, (i == 0) ? 8'h5A : 8'hC3, (i % 4) == 0);
            obs = dut_obs(1'b0);
            checks++;
            if (obs !== model_obs()) begin
                failures++;
                $display("FAIL paced i=%0d actual=%b required=%b", i, obs, model_obs());
            end
            if (obs[1] && dones == 0) active_first++;
            if (obs[1] && !prev_active && dones == 1) restart_cyc = i;
            if (obs[0]) begin
                dones++;
                if (dones == 1) done_cyc = i;
            end
            prev_active = obs[1];
        end
        checks++;
        if (dones != 2) begin
            failures++;
            $display("FAIL paced_frames actual=%0d required=2", dones);
        end
        checks++;
        if (active_first != 4 * W) begin
            failures++;
            $display("FAIL paced_hold actual=%0d required=%0d", active_first, 4 * W);
        end
        checks++;
        if (restart_cyc != done_cyc + 1) begin
            failures++;
            $display("FAIL paced_reaccept actual=%0d required=%0d", restart_cyc, done_cyc + 1);
        end
        drain();
    endtask

    task automatic test_bit_en_on_accept();
        logic [3:0] obs;
        logic [W-1:0] d;
        m_lsb = 1'b0;
        d = 8'($urandom);
        step(1'b1, d, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step(1'b0, '0, 1'b0);
            obs = dut_obs(1'b0);
            checks++;
            if (obs !== {1'b0, d[W-1], 2'b10}) begin
                failures++;
                $display("FAIL accept_strobe_hold i=%0d actual=%b required=%b", i, obs, {1'b0, d[W-1], 2'b10});
            end
        end
        step(1'b0, '0, 1'b1);
        obs = dut_obs(1'b0);
        checks++;
        if (obs !== {1'b0, d[W-2], 2'b10}) begin
            failures++;
            $display("FAIL accept_strobe_next actual=%0d required=%0d", obs, {1'b0, d[W-2], 2'b10});
        end
        drain();
    endtask

    task automatic test_reset_mid_frame();
        logic [3:0] obs;
        logic [0:W-1] seq;
        int dones = 0;
        m_lsb = 1'b0;
        step(1'b1, 8'hFF, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
        async_rst = 1'b0;
        #1;
        obs = dut_obs(1'b0);
        checks++;
        if (obs !== 4'b1100) begin
            failures++;
            $display("FAIL midframe_reset actual=%b required=1100", obs);
        end
        model_reset();
        for (int i = 0; i < 2; i++) step(1'b1, 8'($urandom), 1'b1);
        async_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b1);
            obs = dut_obs(1'b0);
            checks++;
            if (obs !== 4'b1100) begin
                failures++;
                $display("FAIL post_reset_idle i=%0d actual=%b required=1100", i, obs);
            end
        end
        seq = 8'b00001111;
        step(1'b1, 8'h0F, 1'b1);
        for (int k = 0; k < W + 3; k++) begin
            if (k > 0) step(1'b0, '0, 1'b1);
            obs = dut_obs(1'b0);
            if (obs[0]) dones++;
            checks++;
            if (obs !== model_obs() || (k < W && obs[2] !== seq[k])) begin
                failures++;
                $display("FAIL clean_frame k=%0d actual=%b required=%b", k, obs, model_obs());
            end
        end
        checks++;
        if (dones != 1) begin
            failures++;
            $display("FAIL clean_frame_done actual=%0d required=1", dones);
        end
        drain();
    endtask

    task automatic test_random();
        logic [3:0] obs;
        for (int s = 0; s < 2; s++) begin
            m_lsb = s[0];
            for (int i = 0; i < 400; i++) begin
                step($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 2) != 0);
                obs = dut_obs(m_lsb);
                checks++;
                if (obs !== model_obs()) begin
                    failures++;
                    $display("FAIL random lsb=%0d i=%0d actual=%b required=%b", s, i, obs, model_obs());
                end
            end
            drain();
        end
    endtask

    initial begin
        logic [0:W-1] seq_msb;
        logic [0:W-1] seq_lsb;
        if_m.in_valid = 1'b0; if_m.data_in = '0; if_m.bit_en = 1'b0;
        if_l.in_valid = 1'b0; if_l.data_in = '0; if_l.bit_en = 1'b0;
        seq_msb = 8'b10110001;
        seq_lsb = 8'b10001101;
        test_reset();
        test_bit_order(1'b0, seq_msb, 8'hB1);
        test_bit_order(1'b1, seq_lsb, 8'hB1);
        test_paced_backpressure();
        test_bit_en_on_accept();
        test_reset_mid_frame();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
